// File: rtl/seq_ext_pkg.sv
// =============================================================================
// Module  : seq_ext_pkg
// Brief   : Opcode constants and FSM state encoding for the seq_ext sequencer.
// Revision: 1.0
// =============================================================================
`default_nettype none

package seq_ext_pkg;

    localparam logic [3:0] OP_NO   = 4'd0;
    localparam logic [3:0] OP_CI   = 4'd1;
    localparam logic [3:0] OP_CR   = 4'd2;
    localparam logic [3:0] OP_JI   = 4'd3;
    localparam logic [3:0] OP_JR   = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_CALL = 4'd6;
    localparam logic [3:0] OP_RET  = 4'd7;
    localparam logic [3:0] OP_WAIT = 4'd8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_ext_stack.sv
// =============================================================================
// Module  : seq_ext_stack
// Brief   : Return-address LIFO with full/empty flags; pointer reset async.
// Revision: 1.0
// =============================================================================
`default_nettype none

module seq_ext_stack #(
    parameter int ADDR_W  = 8,
    parameter int STACK_D = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [ADDR_W-1:0] mem_q [2**IDX_W];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  top_ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign top_ptr = ptr_q - PTR_W'(1);
    assign wr_idx  = IDX_W'(ptr_q);
    assign top_idx = IDX_W'(top_ptr);
    assign full_o  = (ptr_q == PTR_W'(STACK_D));
    assign empty_o = (ptr_q == '0);
    assign data_o  = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (push_i && !full_o) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = top_ptr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents need no reset: an empty pointer masks them.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_ext.sv
// =============================================================================
// Module  : seq_ext
// Brief   : Parametrised instruction sequencer with call stack and WAIT stall.
// Revision: 1.0
// =============================================================================
`default_nettype none

module seq_ext
    import seq_ext_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CMD_W   = 4,
    parameter int DEV_N   = 8,
    parameter int SRC_N   = 4,
    parameter int STACK_D = 4,
    localparam int DEV_W  = $clog2(DEV_N),
    localparam int SRC_W  = $clog2(SRC_N),
    localparam int INST_W = 4 + ADDR_W + DATA_W + SRC_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [INST_W-1:0]       inst,
    input  logic                    inst_en,
    input  logic [SRC_N*DATA_W-1:0] ireg,
    input  logic [DEV_N-1:0]        dev_ready,
    output logic [ADDR_W-1:0]       next,
    output logic [CMD_W+DATA_W-1:0] oreg,
    output logic [DEV_N-1:0]        oreg_wen,
    output logic                    error
);

    state_t                  state_q;
    logic [ADDR_W-1:0]       next_q;
    logic [CMD_W+DATA_W-1:0] oreg_q;
    logic [DEV_N-1:0]        wen_q;
    logic                    error_q;
    logic [DEV_W-1:0]        wdev_q;

    logic [3:0]        op;
    logic [ADDR_W-1:0] a_fld;
    logic [DATA_W-1:0] b_fld;
    logic [SRC_W-1:0]  s_fld;
    logic [DEV_W-1:0]  dev;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] mux;
    logic [ADDR_W-1:0] jr_addr;
    logic [ADDR_W-1:0] next_inc;
    logic [DEV_N-1:0]  dev_onehot;
    logic              dev_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    assign op         = inst[INST_W-1 -: 4];
    assign a_fld      = inst[SRC_W+DATA_W +: ADDR_W];
    assign b_fld      = inst[SRC_W +: DATA_W];
    assign s_fld      = inst[SRC_W-1:0];
    assign dev        = a_fld[CMD_W +: DEV_W];
    assign cmd        = a_fld[CMD_W-1:0];
    assign mux        = ireg[int'(s_fld)*DATA_W +: DATA_W];
    assign next_inc   = next_q + ADDR_W'(1);
    assign dev_onehot = {{(DEV_N-1){1'b0}}, 1'b1} << dev;
    assign dev_ok     = (int'(dev) < DEV_N);

    generate
        if (DATA_W >= ADDR_W) begin : g_jr_trunc
            assign jr_addr = mux[ADDR_W-1:0];
        end else begin : g_jr_ext
            assign jr_addr = {{(ADDR_W-DATA_W){1'b0}}, mux};
        end
    endgenerate

    assign issue = (state_q == ST_READY) && inst_en;
    assign push  = issue && (op == OP_CALL) && !stk_full;
    assign pop   = issue && (op == OP_RET) && !stk_empty;

    seq_ext_stack #(
        .ADDR_W  (ADDR_W),
        .STACK_D (STACK_D)
    ) u_stack (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (next_inc),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            next_q  <= '0;
            oreg_q  <= '0;
            wen_q   <= '0;
            error_q <= 1'b0;
            wdev_q  <= '0;
        end else begin
            oreg_q <= '0;
            wen_q  <= '0;
            case (state_q)
                ST_RESET: state_q <= ST_READY;
                ST_READY: begin
                    if (inst_en) begin
                        case (op)
                            OP_NO: next_q <= next_inc;
                            OP_CI, OP_CR: begin
                                if (dev_ok) begin
                                    oreg_q <= {cmd, (op == OP_CI) ? b_fld : mux};
                                    wen_q  <= dev_onehot;
                                    next_q <= next_inc;
                                end else begin
                                    state_q <= ST_ERROR;
                                    next_q  <= '0;
                                    error_q <= 1'b1;
                                end
                            end
                            OP_JI: next_q <= a_fld;
                            OP_JR: next_q <= jr_addr;
                            OP_JZ: next_q <= (mux == '0) ? a_fld : next_inc;
                            OP_CALL: begin
                                if (!stk_full) begin
                                    next_q <= a_fld;
                                end else begin
                                    state_q <= ST_ERROR;
                                    next_q  <= '0;
                                    error_q <= 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (!stk_empty) begin
                                    next_q <= stk_top;
                                end else begin
                                    state_q <= ST_ERROR;
                                    next_q  <= '0;
                                    error_q <= 1'b1;
                                end
                            end
                            OP_WAIT: begin
                                if (!dev_ok) begin
                                    state_q <= ST_ERROR;
                                    next_q  <= '0;
                                    error_q <= 1'b1;
                                end else if (dev_ready[dev]) begin
                                    next_q <= next_inc;
                                end else begin
                                    wdev_q  <= dev;
                                    state_q <= ST_WAIT;
                                end
                            end
                            default: begin
                                state_q <= ST_ERROR;
                                next_q  <= '0;
                                error_q <= 1'b1;
                            end
                        endcase
                    end
                end
                // Instruction input is deliberately ignored while stalled.
                ST_WAIT: begin
                    if (dev_ready[wdev_q]) begin
                        next_q  <= next_inc;
                        state_q <= ST_READY;
                    end
                end
                default: begin
                    next_q  <= '0;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    assign next     = next_q;
    assign oreg     = oreg_q;
    assign oreg_wen = wen_q;
    assign error    = error_q;

endmodule

`default_nettype wire

// File: doc/seq_ext.md
# seq_ext

Parametrised next-generation instruction sequencer for the controller datapath. It fetches one instruction per enabled cycle from program memory (address on `next`) and issues device commands on a one-hot write-enabled output register. It adds, over the fixed 8-bit sequencer:
- parametrised widths, device count and source count;
- a bounded call/return stack;
- a WAIT instruction that stalls on a per-device ready handshake.

## Interface
Parameters:
- `ADDR_W`, 8, program address width; also width of the label/dev-cmd field.
- `DATA_W`, 8, immediate and input-register width.
- `CMD_W`, 4, device command width.
- `DEV_N`, 8, number of devices; `DEV_W = clog2(DEV_N)`; requires `DEV_W + CMD_W <= ADDR_W`.
- `SRC_N`, 4, number of input registers; `SRC_W = clog2(SRC_N)`.
- `STACK_D`, 4, call-stack depth (>= 1).
- Derived: `INST_W = 4 + ADDR_W + DATA_W + SRC_W`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `inst`  in  INST_W  instruction: `{op[3:0], a[ADDR_W], b[DATA_W], s[SRC_W]}`. For device ops, `a = {0, dev[DEV_W], cmd[CMD_W]}`.
- `inst_en`  in  1  `inst` valid this cycle.
- `ireg`  in  SRC_N*DATA_W  input registers, packed; register k at `[k*DATA_W +: DATA_W]`.
- `dev_ready`  in  DEV_N  per-device ready level.
- `next`  out  ADDR_W  program counter.
- `oreg`  out  CMD_W+DATA_W  `{cmd, data}` command word.
- `oreg_wen`  out  DEV_N  one-hot device write strobe.
- `error`  out  1  high while in Error.

## Operation
- States:
  - Reset: entered on reset. Always goes to Ready on the next clock.
  - Ready.
  - Wait.
  - Error: sticky; left only by reset.
- Reset values:
  - `next`, `oreg`, `oreg_wen` and the stack pointer = 0.
  - `error` = 0.
  - State = Reset.
- Ready with `inst_en` = 0: hold `next`; `oreg` and `oreg_wen` = 0.
- Opcodes (Ready with `inst_en` = 1). `mux` = `ireg[s]`.
  - 0 NO: `next` + 1.
  - 1 CI: `oreg` = `{cmd, b}`, `oreg_wen` = `1 << dev`, `next` + 1.
  - 2 CR: `oreg` = `{cmd, mux}`, `oreg_wen` = `1 << dev`, `next` + 1.
  - 3 JI: `next` = `a`.
  - 4 JR: `next` = `mux` (zero-extended or truncated to ADDR_W).
  - 5 JZ: `next` = `a` if `mux` == 0, else `next` + 1.
  - 6 CALL: push `next` + 1, then `next` = `a`. Stack full -> Error.
  - 7 RET: `next` = pop. Stack empty -> Error.
  - 8 WAIT dev: if `dev_ready[dev]` = 1 this cycle, `next` + 1 and stay Ready. Otherwise latch `dev`, hold `next` and go to Wait.
  - 9–15: Error.
  - `dev >= DEV_N` on CI/CR/WAIT: Error.
- Wait:
  - `inst_en` and `inst` are ignored; `next` is held.
  - `oreg` and `oreg_wen` = 0.
  - When `dev_ready[latched dev]` = 1: `next` + 1, go to Ready.
- Error: `next` = 0, `oreg` = 0, `oreg_wen` = 0, `error` = 1; stack contents are don't-care.
- Arithmetic: `next` + 1 wraps modulo 2^ADDR_W (`2^ADDR_W - 1` -> 0). A pushed return address wraps the same way.
- Non-command cycles drive `oreg` and `oreg_wen` to 0. They are never held.

## Timing
- All outputs are registered.
- The effect of an instruction presented with `inst_en` at edge N is visible after edge N.
- `oreg_wen` is a single-cycle pulse per CI/CR.
- WAIT with ready already high costs 1 cycle. Otherwise, the exit edge is the first edge sampling ready = 1 while in Wait.
- CALL at full depth: the push is suppressed and the state becomes Error at the same edge.
- Reset asserted mid-operation (including Wait) clears all outputs and the stack pointer asynchronously. The first Ready cycle is 2 edges after deassertion.

## Structure
- Package `seq_ext_pkg`: opcode constants (`OP_NO` … `OP_WAIT`) and state encoding (Reset = 0, Ready = 1, Wait = 2, Error = 3).
- Sub-module `seq_ext_stack`:
  - LIFO, `STACK_D` x `ADDR_W`, with push/pop, full/empty flags and an async reset of the pointer.
  - Push and pop are never simultaneous.

## Test plan
- Reset then NO x3 with `inst_en` = 1 -> `next` = 0, 0 (Reset cycle), 1, 2, 3; `oreg_wen` stays 0.
- CI dev=5, cmd=0xA, b=0x3C -> one cycle with `oreg` = 0xA3C and `oreg_wen` = 0x20; 0 the next cycle. CR s=2 with `ireg[2]` = 0x7F -> `oreg` data = 0x7F.
- `next` = 0x10, CALL 0x40, then RET -> `next` = 0x40, then 0x11. Five nested CALLs (STACK_D = 4) -> `error` = 1 and `next` = 0. RET on an empty stack -> Error.
- WAIT dev=3 with `dev_ready` = 0 for 4 cycles, then 1 -> `next` held for 4 edges, then +1; `inst_en` toggling during Wait has no effect.
- JZ 0x20 with mux = 0 -> `next` = 0x20; with mux = 1 -> `next` + 1. At `next` = 0xFF, NO -> 0x00. Opcode 0xC -> Error, sticky until reset.
- Assert reset while in Wait -> outputs 0 immediately, without waiting for a clock edge.
